gate_model_bist: RTL and testbench
==================================

Name: gate_model_bist

Overview:
Parametrised built-in self-test wrapper for combinational gate models in the gate library. An LFSR drives pseudo-random patterns into the gate model's inputs, and a MISR compacts the model's outputs into a signature. At the end of a run the signature is compared against a golden value. This replaces hand-applied stimulus with one start/done handshake, supports any input and output width, and can hold each pattern for several cycles to allow settling.

Parameters:
IN_W, 13, gate-model input count and LFSR width (>=2)
OUT_W, 10, gate-model output count (1..SIG_W)
SIG_W, 16, MISR/signature width
PATTERNS, 256, patterns applied per run (>=1)
HOLD, 1, cycles each pattern is held; capture happens on the last of these (>=1)
LFSR_TAPS, 13'h1B00, LFSR feedback mask (IN_W bits)
LFSR_SEED, 1, LFSR start value; an all-zero seed is replaced by 1
SIG_TAPS, 16'hB400, MISR feedback mask (SIG_W bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a run; sampled only in IDLE or DONE
golden  in  SIG_W  expected signature; sampled in the cycle the run completes
dut_out  in  OUT_W  gate-model outputs (combinational response to dut_in)
dut_in  out  IN_W  registered pattern driven to the gate model
busy  out  1  high while a run is in progress
done  out  1  high from run completion until the next accepted start or reset
pass  out  1  signature == golden; valid while done=1, 0 otherwise
signature  out  SIG_W  current MISR contents

Behaviour:
- Reset values (clk edge with rst=1): state IDLE; dut_in=0; busy=0; done=0; pass=0; signature=0; pattern counter=0; hold counter=0. rst overrides everything, including mid-run; a run in progress is abandoned without done.
- FSM has three states: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at an edge:
  - lfsr and dut_in <= LFSR_SEED (or 1 if LFSR_SEED==0); misr <= 0; counters <= 0.
  - done <= 0, pass <= 0, busy <= 1; state <= RUN.
- IDLE/DONE, start=0: all outputs hold their values.
- RUN, each edge: hold counter increments. When it reaches HOLD-1 (capture edge):
  - misr <= {misr[SIG_W-2:0], ^(misr & SIG_TAPS)} XOR zero-extended dut_out.
  - lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}, and dut_in follows lfsr.
  - hold counter <= 0; pattern counter increments.
- Last capture edge (pattern counter == PATTERNS-1):
  - state <= DONE; busy <= 0; done <= 1.
  - pass <= (next misr value == golden).
  - dut_in <= 0, so the model inputs are quiet after the run.
- start while in RUN is ignored.
- start in DONE restarts immediately; done drops in the same edge that busy rises.
- Timing: a run occupies PATTERNS*HOLD edges after the start edge. busy is high for exactly PATTERNS*HOLD cycles.
- The LFSR repeats with its own period; PATTERNS larger than the period simply repeats patterns, which is legal.
- Counters are wide enough for PATTERNS and HOLD; there is no wrap inside a run.
- signature is the live MISR value and stays frozen in DONE until the next start.

Test Plan:
1. Reset value check. Assert rst mid-run → next cycle shows dut_in=0, busy=0, done=0, pass=0, signature=0, state IDLE; a subsequent start works normally.
2. LFSR sequence. IN_W=4, LFSR_TAPS=4'b1100, seed 1, HOLD=1, PATTERNS=15; dut_out tied 0.
   - dut_in sequence must be 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8.
   - busy high for 15 cycles; signature=0; golden=0 gives pass=1.
3. Loopback signature. IN_W=OUT_W=SIG_W=4, SIG_TAPS=4'b1100, PATTERNS=4, dut_out=dut_in.
   - MISR must step 1,0,4,0, ending with signature=0.
   - golden=0 gives pass=1; rerun with golden=1 gives pass=0 and signature=0.
4. Hold timing. Same setup as scenario 2 with HOLD=3, PATTERNS=3.
   - dut_in shows 1,1,1,2,2,2,4,4,4; busy high for 9 cycles.
   - Capture happens on the 3rd cycle of each pattern only: inject a dut_out glitch in the first two cycles and confirm the signature is unchanged.
5. Handshake. start pulsed during RUN → ignored; run length is unchanged. start held high through DONE → a new run starts immediately, done is high for exactly one cycle, and pass clears.
6. Zero seed. LFSR_SEED=0 → the first pattern is 1 and the sequence matches scenario 2.

Source files
------------

// File: rtl/gate_model_bist.sv
// BIST wrapper for a combinational gate model. An LFSR drives the model inputs and
// a MISR compacts its outputs. The final signature is compared against a golden value.
module gate_model_bist #(
    parameter int              IN_W      = 13,
    parameter int              OUT_W     = 10,
    parameter int              SIG_W     = 16,
    parameter int              PATTERNS  = 256,
    parameter int              HOLD      = 1,
    parameter logic [IN_W-1:0] LFSR_TAPS = 13'h1B00,
    parameter logic [IN_W-1:0] LFSR_SEED = 1,
    parameter logic [SIG_W-1:0] SIG_TAPS = 16'hB400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] golden,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int PC_W = (PATTERNS > 1) ? $clog2(PATTERNS + 1) : 1;
    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam logic [IN_W-1:0]  SEED     = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [PC_W-1:0]  PAT_LAST = PC_W'(PATTERNS - 1);
    localparam logic [HC_W-1:0]  HOLD_END = HC_W'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  lfsr;
    logic [PC_W-1:0]  pat_cnt;
    logic [HC_W-1:0]  hold_cnt;
    logic [IN_W-1:0]  lfsr_next;
    logic [SIG_W-1:0] misr_next;
    logic             capture;
    logic             last;

    always_comb begin
        lfsr_next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
        misr_next = {signature[SIG_W-2:0], ^(signature & SIG_TAPS)} ^ SIG_W'(dut_out);
        capture   = (hold_cnt == HOLD_END);
        last      = capture && (pat_cnt == PAT_LAST);
    end

    // NOTE: all state updates use <= so every register samples pre-edge values
    // and the block order does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= '0;
            dut_in    <= '0;
            signature <= '0;
            pat_cnt   <= '0;
            hold_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr      <= SEED;
                        dut_in    <= SEED;
                        signature <= '0;
                        pat_cnt   <= '0;
                        hold_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        signature <= misr_next;
                        lfsr      <= lfsr_next;
                        hold_cnt  <= '0;
                        pat_cnt   <= pat_cnt + 1'b1;
                        if (last) begin
                            // Quiet the model inputs once the run is over.
                            dut_in <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (misr_next == golden);
                            state  <= DONE;
                        end else begin
                            dut_in <= lfsr_next;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_model_bist.sv
// Directed bench for gate_model_bist: four small instances cover LFSR order,
// MISR loopback, pattern hold, handshake and zero-seed substitution.
module tb_gate_model_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int vectors = 0;
    int errors  = 0;

    logic       s2, s3, s4, s6;
    logic [3:0] g2, g3, g4, g6;
    logic [3:0] o4;
    logic       loop4;
    logic [3:0] in2, in3, in4, in6;
    logic [3:0] sig2, sig3, sig4, sig6;
    logic       busy2, busy3, busy4, busy6;
    logic       done2, done3, done4, done6;
    logic       pass2, pass3, pass4, pass6;
    logic [3:0] o4_mux;

    assign o4_mux = loop4 ? in4 : o4;

    logic [3:0] exp_seq  [0:14] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [3:0] exp_misr [0:3]  = '{4'h1, 4'h0, 4'h4, 4'h0};
    logic [3:0] exp_hold [0:8]  = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4};

    // LFSR sequence / handshake instance, outputs tied low.
    gate_model_bist #(.IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(15), .HOLD(1),
                      .LFSR_TAPS(4'b1100), .LFSR_SEED(4'd1), .SIG_TAPS(4'b1100)) u_d2 (
        .clk(clk), .rst(rst), .start(s2), .golden(g2), .dut_out(4'h0),
        .dut_in(in2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

    // Loopback instance: model outputs equal model inputs.
    gate_model_bist #(.IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(4), .HOLD(1),
                      .LFSR_TAPS(4'b1100), .LFSR_SEED(4'd1), .SIG_TAPS(4'b1100)) u_d3 (
        .clk(clk), .rst(rst), .start(s3), .golden(g3), .dut_out(in3),
        .dut_in(in3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));

    // Hold-timing instance.
    gate_model_bist #(.IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(3), .HOLD(3),
                      .LFSR_TAPS(4'b1100), .LFSR_SEED(4'd1), .SIG_TAPS(4'b1100)) u_d4 (
        .clk(clk), .rst(rst), .start(s4), .golden(g4), .dut_out(o4_mux),
        .dut_in(in4), .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));

    // Zero-seed instance.
    gate_model_bist #(.IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(15), .HOLD(1),
                      .LFSR_TAPS(4'b1100), .LFSR_SEED(4'd0), .SIG_TAPS(4'b1100)) u_d6 (
        .clk(clk), .rst(rst), .start(s6), .golden(g6), .dut_out(4'h0),
        .dut_in(in6), .busy(busy6), .done(done6), .pass(pass6), .signature(sig6));

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++; if ({in2, sig2, busy2, done2, pass2} !== 11'd0) begin errors++;
            $display("FAIL reset_init: got %h expected 0", {in2, sig2, busy2, done2, pass2}); end
        vectors++; if ({in6, sig6, busy6, done6, pass6} !== 11'd0) begin errors++;
            $display("FAIL reset_init_d6: got %h expected 0", {in6, sig6, busy6, done6, pass6}); end
        // Abandon a loopback run after its first capture.
        g3 = 4'h0; s3 = 1'b1;
        @(negedge clk); s3 = 1'b0;
        @(negedge clk);
        vectors++; if (sig3 !== 4'h1 || in3 !== 4'h2) begin errors++;
            $display("FAIL reset_premid: got sig=%h in=%h expected sig=1 in=2", sig3, in3); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        vectors++; if (in3 !== 4'h0) begin errors++; $display("FAIL reset_dut_in: got %h expected 0", in3); end
        vectors++; if (sig3 !== 4'h0) begin errors++; $display("FAIL reset_sig: got %h expected 0", sig3); end
        vectors++; if ({busy3, done3, pass3} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy3, done3, pass3}); end
        @(negedge clk);
        vectors++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin errors++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy3, done3); end
        // A fresh run after reset behaves normally.
        s3 = 1'b1;
        @(negedge clk); s3 = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !done3; i++) begin
            if (busy3) n++;
            @(negedge clk);
        end
        vectors++; if (n !== 4 || done3 !== 1'b1 || pass3 !== 1'b1) begin errors++;
            $display("FAIL reset_rerun: got busy_cycles=%0d done=%b pass=%b expected 4 1 1", n, done3, pass3); end
    endtask

    task automatic test_lfsr_sequence();
        int n = 0;
        g2 = 4'h0; s2 = 1'b1;
        @(negedge clk); s2 = 1'b0;
        for (int i = 0; i < 40 && !done2; i++) begin
            if (busy2) begin
                if (n < 15) begin
                    vectors++; if (in2 !== exp_seq[n]) begin errors++;
                        $display("FAIL lfsr_seq[%0d]: got %h expected %h", n, in2, exp_seq[n]); end
                end
                n++;
            end
            @(negedge clk);
        end
        vectors++; if (n !== 15) begin errors++; $display("FAIL lfsr_busy_len: got %0d expected 15", n); end
        vectors++; if (done2 !== 1'b1 || pass2 !== 1'b1 || sig2 !== 4'h0) begin errors++;
            $display("FAIL lfsr_result: got done=%b pass=%b sig=%h expected 1 1 0", done2, pass2, sig2); end
        vectors++; if (in2 !== 4'h0) begin errors++; $display("FAIL lfsr_quiet: got %h expected 0", in2); end
    endtask

    task automatic test_loopback();
        g3 = 4'h0; s3 = 1'b1;
        @(negedge clk); s3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (sig3 !== exp_misr[k]) begin errors++;
                $display("FAIL misr_step[%0d]: got %h expected %h", k, sig3, exp_misr[k]); end
        end
        vectors++; if (done3 !== 1'b1 || pass3 !== 1'b1) begin errors++;
            $display("FAIL loop_pass: got done=%b pass=%b expected 1 1", done3, pass3); end
        g3 = 4'h1; s3 = 1'b1;
        @(negedge clk); s3 = 1'b0;
        for (int i = 0; i < 40 && !done3; i++) @(negedge clk);
        vectors++; if (done3 !== 1'b1 || pass3 !== 1'b0 || sig3 !== 4'h0) begin errors++;
            $display("FAIL loop_badgolden: got done=%b pass=%b sig=%h expected 1 0 0", done3, pass3, sig3); end
    endtask

    task automatic test_hold();
        int n = 0;
        int c = 0;
        loop4 = 1'b0; g4 = 4'h0; s4 = 1'b1;
        @(negedge clk); s4 = 1'b0;
        while (c < 40 && !done4) begin
            // Glitch on non-capture cycles, clean value on the capture cycle.
            o4 = (c % 3 == 2) ? 4'h0 : 4'hF;
            if (busy4) begin
                if (n < 9) begin
                    vectors++; if (in4 !== exp_hold[n]) begin errors++;
                        $display("FAIL hold_seq[%0d]: got %h expected %h", n, in4, exp_hold[n]); end
                end
                n++;
            end
            @(negedge clk);
            c++;
        end
        vectors++; if (n !== 9) begin errors++; $display("FAIL hold_busy_len: got %0d expected 9", n); end
        vectors++; if (sig4 !== 4'h0 || pass4 !== 1'b1) begin errors++;
            $display("FAIL hold_glitch: got sig=%h pass=%b expected 0 1", sig4, pass4); end
        // Signature stays frozen in DONE whatever the model does.
        o4 = 4'hF;
        repeat (2) @(negedge clk);
        vectors++; if (sig4 !== 4'h0 || done4 !== 1'b1) begin errors++;
            $display("FAIL hold_frozen: got sig=%h done=%b expected 0 1", sig4, done4); end
        loop4 = 1'b1; g4 = 4'h4; s4 = 1'b1;
        @(negedge clk); s4 = 1'b0;
        for (int i = 0; i < 40 && !done4; i++) @(negedge clk);
        vectors++; if (sig4 !== 4'h4 || pass4 !== 1'b1 || done4 !== 1'b1) begin errors++;
            $display("FAIL hold_loop: got sig=%h pass=%b done=%b expected 4 1 1", sig4, pass4, done4); end
        loop4 = 1'b0; o4 = 4'h0;
    endtask

    task automatic test_handshake();
        int n = 0;
        g2 = 4'h0; s2 = 1'b1;
        @(negedge clk); s2 = 1'b0;
        for (int c = 0; c < 40 && !done2; c++) begin
            s2 = (c == 5);
            if (busy2) n++;
            @(negedge clk);
        end
        s2 = 1'b0;
        vectors++; if (n !== 15 || done2 !== 1'b1) begin errors++;
            $display("FAIL hs_ignore: got busy_cycles=%0d done=%b expected 15 1", n, done2); end
        // Start held high across the whole run and into DONE.
        s2 = 1'b1;
        @(negedge clk);
        n = 0;
        for (int c = 0; c < 40 && !done2; c++) begin
            if (busy2) n++;
            @(negedge clk);
        end
        vectors++; if (n !== 15 || done2 !== 1'b1 || pass2 !== 1'b1) begin errors++;
            $display("FAIL hs_held_run: got busy_cycles=%0d done=%b pass=%b expected 15 1 1", n, done2, pass2); end
        @(negedge clk);
        vectors++; if (done2 !== 1'b0 || busy2 !== 1'b1 || pass2 !== 1'b0 || in2 !== 4'h1) begin errors++;
            $display("FAIL hs_restart: got done=%b busy=%b pass=%b in=%h expected 0 1 0 1", done2, busy2, pass2, in2); end
        s2 = 1'b0;
        for (int i = 0; i < 40 && !done2; i++) @(negedge clk);
        vectors++; if (done2 !== 1'b1) begin errors++; $display("FAIL hs_finish: got done=%b expected 1", done2); end
    endtask

    task automatic test_zero_seed();
        int n = 0;
        g6 = 4'h0; s6 = 1'b1;
        @(negedge clk); s6 = 1'b0;
        for (int i = 0; i < 40 && !done6; i++) begin
            if (busy6) begin
                if (n < 15) begin
                    vectors++; if (in6 !== exp_seq[n]) begin errors++;
                        $display("FAIL zseed_seq[%0d]: got %h expected %h", n, in6, exp_seq[n]); end
                end
                n++;
            end
            @(negedge clk);
        end
        vectors++; if (n !== 15 || pass6 !== 1'b1) begin errors++;
            $display("FAIL zseed_end: got busy_cycles=%0d pass=%b expected 15 1", n, pass6); end
    endtask

    initial begin
        rst = 1'b0;
        {s2, s3, s4, s6} = 4'b0;
        {g2, g3, g4, g6} = 16'h0;
        o4 = 4'h0; loop4 = 1'b0;
        test_reset();
        test_lfsr_sequence();
        test_loopback();
        test_hold();
        test_handshake();
        test_zero_seed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
